cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/fcpu_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr_picker.sv | 32 +++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// Shared CPU constants and types for the common data bus (CDB).
// A CDB packet is {rsv_id, data}; the arbiter and reservation stations
// both take their widths from here.
package fcpu_pkg;

  localparam int RSV_ID_W  = 4;
  localparam int DATA_W    = 32;
  localparam int CDB_W     = RSV_ID_W + DATA_W;
  localparam int CDB_N_REQ = 4;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_pkt_t;

  // Index width for an N-entry one-hot vector, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker. Searches req upward, modulo N,
// starting one past last, and returns the first set bit as both a
// one-hot vector and an encoded index. any=0 when req is all zero.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotating priority search; the first hit after last wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks at most one functional-unit result per
// cycle (round-robin), and broadcasts it one cycle later on a registered
// bus. There is no backpressure on the bus itself.
// Optional build macro CDB_ARB_PRIO0_EN: requester 0 (load unit) wins
// whenever it is valid; such priority grants leave the round-robin
// pointer untouched.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_REQ = CDB_N_REQ
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   clear,
  input  logic [N_REQ*CDB_W-1:0] req_cdb,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  output logic [CDB_W-1:0]       cdb,
  output logic                   cdb_valid,
  output logic [N_REQ-1:0]       grant
);

  localparam int IW = idx_w(N_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  logic [IW-1:0]    last_grant;
  logic [N_REQ-1:0] rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;

  logic [N_REQ-1:0] sel_gnt;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic             accept_en;
  cdb_pkt_t         sel_pkt;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .any  (rr_any)
  );

`ifdef CDB_ARB_PRIO0_EN
  logic prio_hit;

  // Load unit overrides the rotation whenever it has a result.
  always_comb begin
    prio_hit = req_valid[0];
    if (prio_hit) begin
      sel_gnt = N_REQ'(1);
      sel_idx = '0;
      sel_any = 1'b1;
    end else begin
      sel_gnt = rr_gnt;
      sel_idx = rr_idx;
      sel_any = rr_any;
    end
  end
`else
  // Pure rotation: the picker result is the selection.
  always_comb begin
    sel_gnt = rr_gnt;
    sel_idx = rr_idx;
    sel_any = rr_any;
  end
`endif

  // Nothing is accepted during reset or a flush.
  always_comb begin
    accept_en = nrst && !clear;
    req_ready = accept_en ? sel_gnt : '0;
    sel_pkt   = req_cdb[sel_idx*CDB_W +: CDB_W];
  end

  // Broadcast register and rotation pointer; cdb holds its value when idle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cdb        <= '0;
      cdb_valid  <= 1'b0;
      grant      <= '0;
      last_grant <= LAST_RST;
    end else if (clear) begin
      cdb_valid  <= 1'b0;
      grant      <= '0;
      last_grant <= LAST_RST;
    end else begin
      cdb_valid <= sel_any;
      grant     <= sel_gnt;
      if (sel_any) begin
        cdb <= sel_pkt;
      end
`ifdef CDB_ARB_PRIO0_EN
      if (rr_any && !prio_hit) begin
        last_grant <= rr_idx;
      end
`else
      if (rr_any) begin
        last_grant <= rr_idx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then a randomized
// accept/broadcast scoreboard run.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N  = 4;
  localparam int NV = 29;
  localparam int N_RAND = 10000;

  logic               clk;
  logic               nrst;
  logic               clear;
  logic [N*CDB_W-1:0] req_cdb;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [CDB_W-1:0]   cdb;
  logic               cdb_valid;
  logic [N-1:0]       grant;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (clear),
    .req_cdb   (req_cdb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cdb       (cdb),
    .cdb_valid (cdb_valid),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             rn;
    logic             cl;
    logic [N-1:0]     vld;
    logic [N-1:0]     rdy;
    logic             cv;
    logic [N-1:0]     gnt;
    logic [CDB_W-1:0] dat;
  } vec_t;

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [CDB_W-1:0] dat;
  } bcast_t;

  vec_t   vecs [NV];
  bcast_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data-stability rule: a valid, not-yet-accepted packet must not change.
  logic [N*CDB_W-1:0] prev_cdb;
  logic [N-1:0]       prev_pend;
  initial prev_pend = '0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (prev_pend[i] && req_valid[i] &&
          req_cdb[i*CDB_W +: CDB_W] !== prev_cdb[i*CDB_W +: CDB_W]) begin
        errors++;
        $display("FAIL req_cdb_stable[%0d] at %0t", i, $time);
      end
    end
    prev_pend <= nrst ? (req_valid & ~req_ready) : '0;
    prev_cdb  <= req_cdb;
  end

  logic [CDB_W-1:0] pkt [N];
  logic [N-1:0]     hold;
  logic [N-1:0]     acc;
  int               wait_cnt [N];
  int               max_wait;
  bcast_t           e;

  initial begin
    // rn cl vld rdy cv gnt dat
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 36'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 36'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 36'd0};
`ifdef CDB_ARB_PRIO0_EN
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h1, 36'd1};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h1, 36'd1};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h1, 36'd1};
    vecs[6]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h1, 36'd1};
`else
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 4'h2, 1'b1, 4'h1, 36'd1};
    vecs[4]  = '{1'b1, 1'b0, 4'hF, 4'h4, 1'b1, 4'h2, 36'd2};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 4'h8, 1'b1, 4'h4, 36'd3};
    vecs[6]  = '{1'b1, 1'b0, 4'hF, 4'h1, 1'b1, 4'h8, 36'd4};
`endif
    vecs[7]  = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b1, 4'h1, 36'd1};
    vecs[8]  = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 36'd3};
    vecs[9]  = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 36'd3};
    vecs[10] = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 36'd3};
    vecs[11] = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 36'd3};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h4, 36'd3};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 36'd3};
    vecs[14] = '{1'b1, 1'b0, 4'hA, 4'h8, 1'b0, 4'h0, 36'd3};
    vecs[15] = '{1'b1, 1'b0, 4'hA, 4'h2, 1'b1, 4'h8, 36'd4};
    vecs[16] = '{1'b1, 1'b1, 4'hA, 4'h0, 1'b1, 4'h2, 36'd2};
    vecs[17] = '{1'b1, 1'b0, 4'hA, 4'h2, 1'b0, 4'h0, 36'd2};
    vecs[18] = '{1'b1, 1'b0, 4'hA, 4'h8, 1'b1, 4'h2, 36'd2};
    vecs[19] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h8, 36'd4};
    vecs[20] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 36'd4};
    vecs[21] = '{1'b1, 1'b0, 4'h3, 4'h1, 1'b0, 4'h0, 36'd4};
`ifdef CDB_ARB_PRIO0_EN
    vecs[22] = '{1'b1, 1'b0, 4'h3, 4'h1, 1'b1, 4'h1, 36'd1};
    vecs[23] = '{1'b1, 1'b0, 4'h3, 4'h1, 1'b1, 4'h1, 36'd1};
`else
    vecs[22] = '{1'b1, 1'b0, 4'h3, 4'h2, 1'b1, 4'h1, 36'd1};
    vecs[23] = '{1'b1, 1'b0, 4'h3, 4'h1, 1'b1, 4'h2, 36'd2};
`endif
    vecs[24] = '{1'b1, 1'b0, 4'h2, 4'h2, 1'b1, 4'h1, 36'd1};
    vecs[25] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 36'd2};
    vecs[26] = '{1'b1, 1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 36'd2};
    vecs[27] = '{1'b0, 1'b0, 4'h4, 4'h0, 1'b1, 4'h4, 36'd3};
    vecs[28] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 36'd0};

    // Fixed tags: requester i carries packet value i+1.
    for (int i = 0; i < N; i++) req_cdb[i*CDB_W +: CDB_W] = CDB_W'(i + 1);
    nrst      = 1'b0;
    clear     = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      nrst      = vecs[r].rn;
      clear     = vecs[r].cl;
      req_valid = vecs[r].vld;
      #1;
      check($sformatf("v%0d_req_ready", r), 64'(req_ready), 64'(vecs[r].rdy));
      check($sformatf("v%0d_cdb_valid", r), 64'(cdb_valid), 64'(vecs[r].cv));
      check($sformatf("v%0d_grant", r),     64'(grant),     64'(vecs[r].gnt));
      check($sformatf("v%0d_cdb", r),       64'(cdb),       64'(vecs[r].dat));
    end

    // Randomized run: scoreboard of accepted packets vs broadcasts.
    hold     = '0;
    acc      = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    exp_q.delete();
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hold[i] && acc[i]) hold[i] = 1'b0;
        if (!hold[i] && $urandom_range(0, 99) < 40) begin
          hold[i] = 1'b1;
          pkt[i]  = {RSV_ID_W'(i), DATA_W'($urandom)};
        end
        req_cdb[i*CDB_W +: CDB_W] = pkt[i];
      end
      nrst      = 1'b1;
      clear     = ($urandom_range(0, 99) == 0);
      req_valid = hold;
      #1;
      check("rand_cdb_valid", 64'(cdb_valid), 64'(exp_q.size() > 0));
      if (cdb_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rand_cdb", 64'(cdb), 64'(e.dat));
        check("rand_grant", 64'(grant), 64'(e.gnt));
      end else if (!cdb_valid) begin
        check("rand_grant_idle", 64'(grant), 64'd0);
      end
      acc = req_ready;
      check("rand_ready_subset", 64'(acc & ~req_valid), 64'd0);
      check("rand_ready_onehot", 64'($countones(acc) <= 1), 64'd1);
      check("rand_ready_any", 64'(|acc), 64'((|req_valid) && !clear));
      for (int i = 0; i < N; i++) begin
        if (acc[i]) exp_q.push_back('{acc, pkt[i]});
      end
      for (int i = 0; i < N; i++) begin
`ifdef CDB_ARB_PRIO0_EN
        if (clear || !hold[i] || acc[i] || i == 0 || hold[0]) wait_cnt[i] = 0;
`else
        if (clear || !hold[i] || acc[i]) wait_cnt[i] = 0;
`endif
        else wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end

    // Drain: the last accepted packet must still be broadcast once.
    @(negedge clk);
    req_valid = '0;
    clear     = 1'b0;
    #1;
    check("drain_cdb_valid", 64'(cdb_valid), 64'(exp_q.size() > 0));
    if (cdb_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain_cdb", 64'(cdb), 64'(e.dat));
    end
    @(negedge clk);
    #1;
    check("final_idle", 64'(cdb_valid), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("starvation_bound", 64'(max_wait < N), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
